// File: rtl/conv3x3_window_ctrl_pkg.sv
// Shared definitions for the 3x3 window scheduler: tap indices, FSM encoding
// and the window packing helper.
package conv3x3_window_ctrl_pkg;

  // Taps are row-major, p0 = top-left, p4 = centre, p8 = bottom-right.
  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P3 = 3;
  localparam int P4 = 4;
  localparam int P5 = 5;
  localparam int P6 = 6;
  localparam int P7 = 7;
  localparam int P8 = 8;
  localparam int NUM_TAPS = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // LSB position of tap 'tap' inside the packed window bus.
  function automatic int tap_lsb(input int tap, input int pix_w);
    return tap * pix_w;
  endfunction

endpackage

// File: rtl/conv3x3_window_ctrl_if.sv
// Pixel-in / window-out handshake bundle plus frame control of the window scheduler.
interface conv3x3_window_ctrl_if #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int PIX_W = 8
);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  logic               start;
  logic [PIX_W-1:0]   in_pix;
  logic               in_valid;
  logic               in_ready;
  logic [9*PIX_W-1:0] win;
  logic [ROW_W-1:0]   out_row;
  logic [COL_W-1:0]   out_col;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               frame_done;

  modport master (
    output start, in_pix, in_valid, out_ready,
    input  in_ready, win, out_row, out_col, out_valid, busy, frame_done
  );

  modport slave (
    input  start, in_pix, in_valid, out_ready,
    output in_ready, win, out_row, out_col, out_valid, busy, frame_done
  );
endinterface

// File: rtl/conv3x3_window_ctrl_line_buffer.sv
// One image line of delay: every enabled cycle returns the pixel written DEPTH enables earlier.
module conv3x3_line_buffer #(
  parameter int DEPTH = 256,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [PIX_W-1:0] din_i,
  output logic [PIX_W-1:0] dout_o
);
  // The registered read port is the last stage of the delay, so the RAM holds DEPTH-1 entries.
  localparam int MEM_D  = DEPTH - 1;
  localparam int ADDR_W = (MEM_D > 1) ? $clog2(MEM_D) : 1;

  logic [PIX_W-1:0]  mem [MEM_D];
  logic [PIX_W-1:0]  rd_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  assign ptr_d = (ptr_q == ADDR_W'(MEM_D - 1)) ? '0 : ptr_q + 1'b1;

  // Read-before-write on the same address; contents are never cleared.
  always_ff @(posedge clk) begin
    if (en_i) begin
      rd_q        <= mem[ptr_q];
      mem[ptr_q]  <= din_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (en_i) begin
      ptr_q <= ptr_d;
    end
  end

  assign dout_o = rd_q;

endmodule

// File: rtl/conv3x3_window_ctrl.sv
// Frame scheduler: buffers two lines, emits one zero-padded 3x3 window per pixel in
// raster order, and sequences start / fill / flush / done.
module conv3x3_window_ctrl
  import conv3x3_window_ctrl_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int PIX_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv3x3_window_ctrl_if.slave bus
);
  localparam int ROW_W      = $clog2(IMG_H);
  localparam int COL_W      = $clog2(IMG_W);
  localparam int NUM_PIX    = IMG_W * IMG_H;
  localparam int TOTAL_PUSH = NUM_PIX + IMG_W + 1;
  localparam int K_W        = $clog2(TOTAL_PUSH + 1);

  state_t             state_q;
  logic [K_W-1:0]     k_q;
  logic               busy_q;
  logic               frame_done_q;
  logic               out_valid_q;
  logic [9*PIX_W-1:0] win_q;
  logic [ROW_W-1:0]   out_row_q;
  logic [COL_W-1:0]   out_col_q;
  logic [ROW_W-1:0]   cen_row_q;
  logic [ROW_W-1:0]   cen_row_d;
  logic [COL_W-1:0]   cen_col_q;
  logic [COL_W-1:0]   cen_col_d;
  logic [PIX_W-1:0]   mid_q   [3];
  logic [PIX_W-1:0]   right_q [3];

  logic               adv;
  logic               push;
  logic               load;
  logic [PIX_W-1:0]   push_pix;
  logic [PIX_W-1:0]   lb0_rd;
  logic [PIX_W-1:0]   lb1_rd;
  logic [PIX_W-1:0]   tap_next [NUM_TAPS];
  logic [9*PIX_W-1:0] win_d;
  logic               top_edge, bot_edge, left_edge, right_edge;

  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = (state_q == ST_RUN) && adv;
  assign push         = (state_q == ST_RUN)   ? (bus.in_valid && adv) :
                        (state_q == ST_FLUSH) ? (adv && (k_q != K_W'(TOTAL_PUSH))) : 1'b0;
  assign push_pix     = (state_q == ST_RUN) ? bus.in_pix : '0;
  assign load         = push && (k_q >= K_W'(IMG_W + 1));

  conv3x3_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (push),
    .din_i  (push_pix),
    .dout_o (lb0_rd)
  );

  conv3x3_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (push),
    .din_i  (lb0_rd),
    .dout_o (lb1_rd)
  );

  // Window after this push: old middle/right columns shift left, new column enters right.
  assign tap_next[P0] = mid_q[0];
  assign tap_next[P1] = right_q[0];
  assign tap_next[P2] = lb1_rd;
  assign tap_next[P3] = mid_q[1];
  assign tap_next[P4] = right_q[1];
  assign tap_next[P5] = lb0_rd;
  assign tap_next[P6] = mid_q[2];
  assign tap_next[P7] = right_q[2];
  assign tap_next[P8] = push_pix;

  assign top_edge   = (cen_row_q == '0);
  assign bot_edge   = (cen_row_q == ROW_W'(IMG_H - 1));
  assign left_edge  = (cen_col_q == '0);
  assign right_edge = (cen_col_q == COL_W'(IMG_W - 1));

  // Masking out-of-frame taps also hides line wrap and stale line-buffer data.
  for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
    localparam int DR = gi / 3;
    localparam int DC = gi % 3;
    logic tap_kill;
    assign tap_kill = (DR == 0 && top_edge)  || (DR == 2 && bot_edge) ||
                      (DC == 0 && left_edge) || (DC == 2 && right_edge);
    assign win_d[tap_lsb(gi, PIX_W) +: PIX_W] = tap_kill ? '0 : tap_next[gi];
  end

  assign cen_col_d = right_edge ? '0 : cen_col_q + 1'b1;
  assign cen_row_d = right_edge ? cen_row_q + 1'b1 : cen_row_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        mid_q[i]   <= '0;
        right_q[i] <= '0;
      end
      win_q       <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_valid_q <= 1'b0;
      cen_row_q   <= '0;
      cen_col_q   <= '0;
    end else begin
      if (push) begin
        for (int i = 0; i < 3; i++) mid_q[i] <= right_q[i];
        right_q[0] <= lb1_rd;
        right_q[1] <= lb0_rd;
        right_q[2] <= push_pix;
      end
      if (load) begin
        win_q       <= win_d;
        out_row_q   <= cen_row_q;
        out_col_q   <= cen_col_q;
        out_valid_q <= 1'b1;
        cen_row_q   <= cen_row_d;
        cen_col_q   <= cen_col_d;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (state_q == ST_IDLE && bus.start) begin
        cen_row_q <= '0;
        cen_col_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (push) k_q <= k_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_RUN;
            k_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (push && k_q == K_W'(NUM_PIX - 1)) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          // All pushes issued: leave once the last window has been taken.
          if (k_q == K_W'(TOTAL_PUSH) && out_valid_q && bus.out_ready) begin
            state_q      <= ST_DONE;
            frame_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.win        = win_q;
  assign bus.out_row    = out_row_q;
  assign bus.out_col    = out_col_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: doc/conv3x3_window_ctrl.md
# conv3x3_window_ctrl

Streaming scheduler in front of the 3x3 convolution kernel: accepts one frame of raster-order pixels, buffers two image lines, and emits one zero-padded 3x3 window per pixel, in raster order, with a valid/ready handshake. It owns all frame sequencing (start, fill, flush, done), so the downstream kernel and clip stage stay purely combinational.

## Interface
- IMG_W, 256: pixels per line (≥3)
- IMG_H, 256: lines per frame (≥3)
- PIX_W, 8: bits per pixel
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a frame when idle
- in_pix  in  PIX_W  input pixel
- in_valid  in  1  in_pix valid
- in_ready  out  1  pixel accepted when in_valid && in_ready
- win  out  9*PIX_W  window p0..p8, row-major, p0 at LSBs, p4 = centre pixel
- out_row  out  log2(IMG_H)  row of centre pixel
- out_col  out  log2(IMG_W)  column of centre pixel
- out_valid  out  1  win/out_row/out_col valid
- out_ready  in  1  window consumed when out_valid && out_ready
- busy  out  1  high outside IDLE
- frame_done  out  1  one-cycle pulse after final window handshake

## Operation
- FSM: IDLE, RUN, FLUSH, DONE.
  - IDLE: start → RUN; counters cleared. start in any other state ignored.
  - RUN: accepts exactly IMG_W*IMG_H pixels; after the last accept → FLUSH.
  - FLUSH: pushes IMG_W+1 synthetic zero pixels, no input accepted; after the last push → DONE once the final window handshake completes.
  - DONE: frame_done=1 for one cycle → IDLE.
- adv = !out_valid || out_ready. in_ready = (state==RUN) && adv. push = in-accept in RUN, or adv in FLUSH.
- Each push shifts the pixel into a 3x3 register window fed by two IMG_W-deep line buffers (oldest line top). Push counter k counts pushes, 0-based.
- Pushes k ≥ IMG_W+1 load the output register with the window centred on raster index k−IMG_W−1; pushes 0..IMG_W produce no output. Total outputs = IMG_W*IMG_H.
- Border masking at load time: taps with row<0, row≥IMG_H, col<0 or col≥IMG_W forced to 0. Masking also removes line-wrap contamination; line buffer contents never need clearing.
- out_row/out_col advance raster-order with each loaded window; they wrap col IMG_W−1→0 and row++.
- Arithmetic: counters are unsigned, sized by $clog2; no pixel arithmetic here.

## Timing
- Reset values: in_ready=0, out_valid=0, win=0, out_row=0, out_col=0, busy=0, frame_done=0, FSM=IDLE.
- Latency: the window for centre (r,c) is registered on the clock edge of push r*IMG_W+c+IMG_W+1; out_valid is high in the following cycle.
- Throughput: 1 window/cycle with out_ready held high; out_ready=0 stalls all pushes. In RUN, in_ready drops in the same cycle.
- out_valid stays high with win stable until the handshake; no bubbles while pushes continue.
- The last window handshake and the DONE entry may share a cycle. frame_done fires exactly one cycle later.
- rst_n low mid-frame: all outputs go immediately to reset values. The next frame needs a new start.

## Structure
- Shared package: tap index constants P0..P8, state encoding, and a window-pack function/macro (p_i at bits [i*PIX_W +: PIX_W]).
- Sub-module: conv3x3_line_buffer, a parameterised IMG_W-deep single-port RAM/shift line (read-before-write, one per buffered line, two instances). Quartus infers altsyncram.

## Test plan
- IMG_W=4, IMG_H=3, pixels 1..12, out_ready=1. Required windows:
  - (0,0) → {0,0,0,0,1,2,0,5,6}
  - (1,1) → {1,2,3,5,6,7,9,10,11}
  - (2,3) → {7,8,0,11,12,0,0,0,0}
  - 12 windows in total; frame_done one cycle after the 12th.
- Same frame with out_ready toggling 1-0-0-1 pseudo-randomly. Required: identical window sequence, none dropped or duplicated, win stable while stalled, in_ready=0 whenever a stall blocks a push.
- Latency check, IMG_W=4: first out_valid one cycle after the 6th input accept.
- start pulsed during RUN and FLUSH. Required: ignored, a single frame_done.
- rst_n asserted after 7 accepts, then start and a full frame. Required: outputs zero during reset; the new frame's windows match a clean run exactly, with no stale line-buffer data.
- Two back-to-back frames (start on the frame_done cycle+1, different data). Required: second-frame row 0 shows zero top taps, not first-frame data.
